mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single unified memory port between the instruction-fetch requester (IF) and the load/store requester (LS). It arbitrates between the two, latches the winning request, and sequences one transaction at a time against a variable-latency memory. It returns the completion and read data to the granted requester. It sits between the fetch/memory pipeline stages and the memory model, replacing the separate imem/dmem paths.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive contested LS grants before IF is forced to win
- MAX_WAIT, 15, cycles in BUSY before abort (used only with MEM_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req / if_addr  in  1 / AW  fetch request (read only); level, held until grant
- if_gnt  out  1  grant pulse to IF
- if_rvalid / if_rdata  out  1 / DW  fetch completion pulse and data
- ls_req / ls_we / ls_addr / ls_wdata  in  1 / 1 / AW / DW  load/store request; level, held until grant
- ls_gnt  out  1  grant pulse to LS
- ls_rvalid / ls_rdata  out  1 / DW  LS completion pulse and data (rdata 0 on writes)
- mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  memory request, held until ack
- mem_ack / mem_rdata  in  1 / DW  memory completion pulse and read data (valid with ack)
- err  out  1  abort pulse, coincident with rvalid on timeout; constant 0 without MEM_TIMEOUT_EN
- busy  out  1  high when state ≠ IDLE

## Operation
- States: IDLE, IF_BUSY, LS_BUSY.
- IDLE, arbitration:
  - Only ls_req: grant LS. Only if_req: grant IF.
  - Both: LS wins unless ls_streak == STARVE_LIMIT, then IF wins.
  - The gnt is a combinational pulse in the decision cycle. On the following edge: latch addr/we/wdata into registers and enter the matching BUSY state.
- ls_streak counter:
  - Increments on an LS grant while if_req is high.
  - Clears on any IF grant.
  - Saturates at STARVE_LIMIT.
  - Unchanged on an uncontested LS grant.
- BUSY:
  - mem_req=1, driven from the latched registers.
  - On mem_ack, register mem_rdata (0 if write) into the granted requester's rdata, pulse its rvalid next cycle, and return to IDLE.
- mem_ack in IDLE is ignored. A req dropped before grant is dropped with no side effects. IF is never given mem_we=1.
- Outputs not being driven read 0: rvalid, gnt, mem_req, mem_we. rdata outputs hold their last value.

## Timing
- Reset (asynchronous, immediate): state=IDLE; all gnt, rvalid, mem_req, mem_we, err, busy = 0; mem_addr, mem_wdata, rdata = 0; ls_streak and timeout counter = 0. Reset asserted mid-transaction abandons it with no rvalid.
- Grant at cycle 0 → mem_req first high at cycle 1.
- mem_ack at cycle k ≥ 1 → rvalid at k+1, state=IDLE at k+1.
- A new grant can be issued in cycle k+1, so back-to-back throughput is one transaction per (memory latency + 1) cycles.
- Same-cycle mem_ack with ack latency of one cycle: grant c0, req c1, ack c1, rvalid c2, next grant c2.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches MAX_WAIT without ack, drop mem_req, pulse rvalid and err together next cycle (rdata=0), and return to IDLE.
  - An ack in the same cycle the count reaches MAX_WAIT wins: normal completion, err=0.
- Not defined: no counter; BUSY waits indefinitely; err tied 0.

## Test plan
- Reset, then IF-only read of 0x100, mem_ack 2 cycles after mem_req with rdata 0xDEADBEEF → if_gnt c0, mem_req c1–c3, if_rvalid c4 with 0xDEADBEEF.
- LS write 0x200←0x12345678 with ack same cycle as first mem_req → mem_we=1, mem_wdata=0x12345678, ls_rvalid one cycle later with ls_rdata=0.
- if_req and ls_req held continuously, one-cycle memory → grant order LS,LS,LS,LS,IF,LS… (STARVE_LIMIT=4).
- Reset asserted while LS_BUSY → mem_req and busy drop immediately; no ls_rvalid; after release, pending if_req is granted first cycle.
- With MEM_TIMEOUT_EN, mem_ack never asserted → err and ls_rvalid pulse after MAX_WAIT=15 BUSY cycles; without the macro, mem_req stays high and busy stays 1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the requester and memory buses around the shared memory port.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, which holds both requesters and the memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;

   logic          ls_req;
   logic          ls_we;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic          ls_gnt;
   logic          ls_rvalid;
   logic [DW-1:0] ls_rdata;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (LS). Only one transaction is in flight at a time.
// LS normally wins a contested cycle. After STARVE_LIMIT contested LS grants in a row,
// IF wins the next contested cycle so that fetch always makes progress.
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction after MAX_WAIT cycles
// in BUSY without mem_ack. An abort completes the requester with err=1 and rdata=0.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | no transaction; arbitrate and pulse gnt combinationally
// ST_IF_BUSY | fetch read outstanding on the memory port
// ST_LS_BUSY | load/store outstanding on the memory port
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_WAIT     = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_port_arbiter_if.slave      bus,
   output logic                   err,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_LS_BUSY = 2'd2
   } state_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] ls_rdata_q, ls_rdata_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          ls_rvalid_q, ls_rvalid_d;
   logic          err_q, err_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          streak_full;
   logic          ls_win, if_win;
   logic          if_gnt, ls_gnt;
   logic          timeout;

`ifdef MEM_TIMEOUT_EN
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic [WW-1:0] wait_q, wait_d;

   // This cycle is the MAX_WAIT-th BUSY cycle without an ack. An ack in the same cycle still wins.
   assign timeout = (state_q != ST_IDLE) && (wait_q == WW'(MAX_WAIT - 1));

   // Wait counter: held at zero outside BUSY, so it is clear on entry to BUSY.
   always_comb begin
      wait_d = '0;
      if (state_q != ST_IDLE && !bus.mem_ack && !timeout) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign streak_full = (streak_q == SW'(STARVE_LIMIT));
   assign ls_win      = bus.ls_req && (!bus.if_req || !streak_full);
   assign if_win      = bus.if_req && !ls_win;

   // Next-state, grant and completion logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      err_d       = 1'b0;
      streak_d    = streak_q;
      if_gnt      = 1'b0;
      ls_gnt      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ls_win) begin
               ls_gnt  = 1'b1;
               state_d = ST_LS_BUSY;
               addr_d  = bus.ls_addr;
               we_d    = bus.ls_we;
               wdata_d = bus.ls_wdata;
               // Only contested grants count toward starving IF.
               if (bus.if_req && !streak_full) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (if_win) begin
               if_gnt   = 1'b1;
               state_d  = ST_IF_BUSY;
               addr_d   = bus.if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               streak_d = '0;
            end
         end
         ST_IF_BUSY, ST_LS_BUSY: begin
            if (bus.mem_ack) begin
               state_d = ST_IDLE;
               if (state_q == ST_LS_BUSY) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = we_q ? '0 : bus.mem_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_rdata;
               end
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               if (state_q == ST_LS_BUSY) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = '0;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         err_q       <= 1'b0;
         streak_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         err_q       <= err_d;
         streak_q    <= streak_d;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.ls_gnt    = ls_gnt;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.mem_req   = (state_q != ST_IDLE);
   assign bus.mem_we    = (state_q == ST_LS_BUSY) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign busy          = (state_q != ST_IDLE);
   assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle-level reference model plus a memory responder.
// Completions the model predicts are queued and compared when the DUT produces rvalid.
module tb_mem_port_arbiter;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int STARVE = 4;
   localparam int MAXW   = 15;

   logic clk = 1'b0;
   logic reset;
   logic err, busy;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE), .MAX_WAIT(MAXW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .err   (err),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ls;
      logic [31:0] data;
      bit          err;
      int          due;
   } exp_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // reference model state (value for the current cycle)
   int          m_state;      // 0 idle, 1 IF busy, 2 LS busy
   int          m_streak;
   int          m_wait;
   int          m_lat;
   int          m_gnt;        // who the model granted in the last ticked cycle
   int          m_gnt_cyc;
   logic [31:0] m_addr, m_wdata;
   logic        m_we;
   logic [31:0] m_if_rdata, m_ls_rdata;
   exp_t        sb[$];
   int          glog[$];      // grants observed on the DUT, 1=IF 2=LS

   // memory responder controls
   bit ack_en    = 1'b1;
   bit stray_ack = 1'b0;
   int lat       = 0;
   bit to_en;

   // observations of the DUT
   int          obs_rv_cyc;
   logic        obs_err;
   logic [1:0]  obs_gnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_state    = 0;
      m_streak   = 0;
      m_wait     = 0;
      m_lat      = 0;
      m_gnt      = 0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_if_rdata = '0;
      m_ls_rdata = '0;
      sb.delete();
   endtask

   // One clock cycle. Entered at the negedge, after the test has driven the request inputs.
   task automatic tick();
      logic        ls_w, if_w;
      logic [31:0] mem_d;
      exp_t        e;
      #1;
      ls_w = 1'b0;
      if_w = 1'b0;
      if (m_state == 0) begin
         ls_w = bus.ls_req && (!bus.if_req || m_streak != STARVE);
         if_w = bus.if_req && !ls_w;
      end
      obs_gnt = {bus.ls_gnt, bus.if_gnt};
      if (bus.ls_gnt) glog.push_back(2);
      else if (bus.if_gnt) glog.push_back(1);
      if (bus.if_rvalid || bus.ls_rvalid) begin
         obs_rv_cyc = cyc;
         obs_err    = err;
      end
      chk("if_gnt", bus.if_gnt, if_w);
      chk("ls_gnt", bus.ls_gnt, ls_w);
      chk("busy", busy, m_state != 0);
      chk("mem_req", bus.mem_req, m_state != 0);
      chk("mem_we", bus.mem_we, m_state == 2 && m_we);
      if (m_state != 0) chk("mem_addr", bus.mem_addr, m_addr);
      if (m_state == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("if_rvalid", bus.if_rvalid, !e.ls);
         chk("ls_rvalid", bus.ls_rvalid, e.ls);
         chk("err", err, e.err);
         if (e.ls) m_ls_rdata = e.data;
         else m_if_rdata = e.data;
      end else begin
         chk("if_rvalid_idle", bus.if_rvalid, 1'b0);
         chk("ls_rvalid_idle", bus.ls_rvalid, 1'b0);
         chk("err_idle", err, 1'b0);
      end
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("ls_rdata", bus.ls_rdata, m_ls_rdata);

      // memory responder for this cycle
      mem_d = $urandom;
      if (m_state != 0 && ack_en && m_lat == lat) begin
         bus.mem_ack = 1'b1;
         if (!(m_state == 2 && m_we)) mem_d = mem_val(m_addr);
      end else if (m_state == 0 && stray_ack) begin
         bus.mem_ack = 1'b1;
      end else begin
         bus.mem_ack = 1'b0;
      end
      bus.mem_rdata = mem_d;

      // advance the model to the next cycle
      m_gnt = 0;
      if (m_state == 0) begin
         if (ls_w) begin
            m_state = 2;
            m_addr  = bus.ls_addr;
            m_we    = bus.ls_we;
            m_wdata = bus.ls_wdata;
            if (bus.if_req && m_streak < STARVE) m_streak++;
            m_gnt = 2;
         end else if (if_w) begin
            m_state  = 1;
            m_addr   = bus.if_addr;
            m_we     = 1'b0;
            m_streak = 0;
            m_gnt    = 1;
         end
         if (m_gnt != 0) m_gnt_cyc = cyc;
         m_wait = 0;
         m_lat  = 0;
      end else if (bus.mem_ack) begin
         e.ls   = (m_state == 2);
         e.data = (m_state == 2 && m_we) ? 32'h0 : mem_d;
         e.err  = 1'b0;
         e.due  = cyc + 1;
         sb.push_back(e);
         m_state = 0;
      end else if (to_en && m_wait == MAXW - 1) begin
         e.ls   = (m_state == 2);
         e.data = 32'h0;
         e.err  = 1'b1;
         e.due  = cyc + 1;
         sb.push_back(e);
         m_state = 0;
      end else begin
         m_wait++;
         m_lat++;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_gnt(input int who, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (m_gnt != who && n < budget);
      chk("gnt_seen", m_gnt, who);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_state != 0 || sb.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk("idle_reached", (m_state == 0 && sb.size() == 0), 1'b1);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      bus.if_req  = 1'b0;
      bus.ls_req  = 1'b0;
      bus.mem_ack = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic ls_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int l);
      lat          = l;
      bus.ls_req   = 1'b1;
      bus.ls_we    = we;
      bus.ls_addr  = a;
      bus.ls_wdata = d;
      wait_gnt(2, 20);
      bus.ls_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
`ifdef MEM_TIMEOUT_EN
      to_en = 1'b1;
`else
      to_en = 1'b0;
`endif
      reset         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.ls_req    = 1'b0;
      bus.ls_we     = 1'b0;
      bus.ls_addr   = '0;
      bus.ls_wdata  = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_outs", {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
                       bus.mem_req, bus.mem_we, err, busy}, 8'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
      reset = 1'b1;

      // IF read of 0x100, ack two cycles after the first mem_req
      ack_en      = 1'b1;
      lat         = 2;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      wait_gnt(1, 10);
      bus.if_req = 1'b0;
      wait_idle(20);
      chk("if_rd_latency", obs_rv_cyc - m_gnt_cyc, 4);
      chk("if_rd_data", bus.if_rdata, 32'hDEAD_BEEF);

      // LS read to make ls_rdata non-zero, then a same-cycle-ack write
      ls_op(1'b0, 32'h300, 32'h0, 1);
      wait_idle(20);
      ls_op(1'b1, 32'h200, 32'h1234_5678, 0);
      wait_idle(20);
      chk("wr_latency", obs_rv_cyc - m_gnt_cyc, 2);
      chk("wr_rdata", bus.ls_rdata, 32'h0);

      // ack while idle is ignored; request dropped before grant has no effect
      stray_ack = 1'b1;
      repeat (3) tick();
      stray_ack = 1'b0;
      chk("stray_busy", busy, 1'b0);
      glog.delete();
      ls_op(1'b0, 32'h340, 32'h0, 5);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h180;
      tick();
      tick();
      bus.if_req = 1'b0;
      wait_idle(20);
      repeat (2) tick();
      chk("drop_grants", glog.size(), 1);

      // both held continuously, one-cycle memory
      do_reset();
      glog.delete();
      lat          = 0;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h400;
      bus.ls_req   = 1'b1;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = 32'h800;
      for (int n = 0; n < 200 && glog.size() < 11; n++) tick();
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      wait_idle(20);
      chk("starve_count", glog.size(), 11);
      for (int i = 0; i < glog.size(); i++) chk("starve_order", glog[i], (i % 5 == 4) ? 1 : 2);

      // an uncontested LS grant leaves the streak unchanged
      do_reset();
      glog.delete();
      bus.if_req = 1'b1;
      bus.ls_req = 1'b1;
      for (int n = 0; n < 200 && glog.size() < 6; n++) begin
         tick();
         bus.if_req = (glog.size() != 3);
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      wait_idle(20);
      chk("uncont_count", glog.size(), 6);
      for (int i = 0; i < glog.size(); i++) chk("uncont_order", glog[i], (i == 5) ? 1 : 2);

      // reset asserted while LS_BUSY
      ack_en = 1'b0;
      ls_op(1'b0, 32'h440, 32'h0, 0);
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_req", bus.mem_req, 1'b0);
      model_reset();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h480;
      @(negedge clk);
      chk("rst_mid_no_rvalid", bus.ls_rvalid, 1'b0);
      reset  = 1'b1;
      ack_en = 1'b1;
      lat    = 1;
      tick();
      chk("post_rst_if_gnt", obs_gnt, 2'b01);
      bus.if_req = 1'b0;
      wait_idle(20);

      // memory that never acks
      ls_op(1'b0, 32'h600, 32'h0, 1);
      wait_idle(20);
      ack_en = 1'b0;
      ls_op(1'b0, 32'h500, 32'h0, 0);
`ifdef MEM_TIMEOUT_EN
      wait_idle(40);
      chk("to_latency", obs_rv_cyc - m_gnt_cyc, MAXW + 1);
      chk("to_err", obs_err, 1'b1);
      chk("to_rdata", bus.ls_rdata, 32'h0);
`else
      repeat (20) tick();
      chk("hang_mem_req", bus.mem_req, 1'b1);
      chk("hang_busy", busy, 1'b1);
      do_reset();
`endif

      // ack arriving in the last allowed BUSY cycle completes normally
      ack_en      = 1'b1;
      lat         = MAXW - 1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h700;
      wait_gnt(1, 10);
      bus.if_req = 1'b0;
      wait_idle(40);
      chk("lim_latency", obs_rv_cyc - m_gnt_cyc, MAXW + 1);
      chk("lim_err", obs_err, 1'b0);
      chk("lim_rdata", bus.if_rdata, mem_val(32'h700));

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (!bus.if_req && $urandom_range(0, 2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom;
         end
         if (!bus.ls_req && $urandom_range(0, 2) == 0) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = $urandom_range(0, 1);
            bus.ls_addr  = $urandom;
            bus.ls_wdata = $urandom;
         end
         tick();
         if (m_gnt == 1) bus.if_req = 1'b0;
         if (m_gnt == 2) bus.ls_req = 1'b0;
         if (m_gnt != 0) lat = $urandom_range(0, 3);
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      wait_idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
